// File: rtl/fmap_capture_pkg.sv
// fmap_capture_pkg: shared types and constants
// for the multi-channel FP16 feature-map capture stage.
package fmap_capture_pkg;

  typedef enum logic [1:0] {
    FM_CLAMP  = 2'd0,
    FM_ABS    = 2'd1,
    FM_OFFSET = 2'd2,
    FM_RSVD   = 2'd3
  } fmap_mode_e;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WRITE   = 2'd1,
    HOLDOFF = 2'd2
  } cap_st_e;

  localparam int FP16_BIAS    = 15;
  localparam int FP16_EXP_MAX = 31;

endpackage

// File: rtl/fmap_capture_mc_fp16_to_gray8.sv
// fp16_to_gray8: combinational FP16 pixel to
// 8-bit grayscale mapping (clamp / abs / signed offset).
module fp16_to_gray8
  import fmap_capture_pkg::*;
(
  input  logic [15:0] fp16,
  input  fmap_mode_e  mode,
  output logic [7:0]  gray
);

  logic       sgn;
  logic [4:0] ex;
  logic [7:0] m;
  logic [2:0] sh;
  logic [7:0] mag;
  logic [7:0] half;

  assign sgn  = fp16[15];
  assign ex   = fp16[14:10];
  assign m    = {1'b1, fp16[9:3]};
  assign sh   = 3'(5'(FP16_BIAS) - ex);
  assign half = {1'b0, mag[7:1]};

  // magnitude: saturate large, shift down small exponents
  always_comb begin
    mag = '0;
    if (ex >= 5'(FP16_BIAS + 8))
      mag = 8'hFF;
    else if (ex >= 5'(FP16_BIAS))
      mag = m;
    else if (ex > 5'(FP16_BIAS - 8))
      mag = m >> sh;
  end

  // sign handling per mode, zero and Inf/NaN special cases
  always_comb begin
    gray = '0;
    if (ex == '0) begin
      gray = (mode == FM_OFFSET) ? 8'h80 : 8'h00;
    end else if (ex == 5'(FP16_EXP_MAX)) begin
      gray = 8'hFF;
    end else begin
      case (mode)
        FM_ABS:    gray = mag;
        FM_OFFSET: gray = sgn ? 8'h7F - half
                              : 8'h80 + half;
        default:   gray = sgn ? 8'h00 : mag;
      endcase
    end
  end

endmodule

// File: rtl/fmap_capture_mc.sv
// fmap_capture_mc: captures NUM_CH-channel FP16 columns,
// converts to gray and serialises one BRAM write per channel.
module fmap_capture_mc
  import fmap_capture_pkg::*;
#(
  parameter int PIX_H       = 24,
  parameter int NUM_CH      = 4,
  parameter int BRAM_DW     = 256,
  parameter int ADDR_W      = 12,
  parameter int BASE_ADDR   = 'h000,
  parameter int CH_STRIDE   = 'h020,
  parameter int TIMEOUT_CYC = 100
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                valid_col,
  output logic                                ready_col,
  input  logic [NUM_CH-1:0][PIX_H-1:0][15:0]  data_col,
  input  logic [1:0]                          cfg_mode,
  output logic [ADDR_W-1:0]                   bram_addr_a,
  output logic [BRAM_DW-1:0]                  bram_wrdata_a,
  output logic [BRAM_DW/8-1:0]                bram_we_a,
  output logic                                write_done,
  output logic                                busy,
  output logic [15:0]                         frame_cnt
);

  localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int COL_W = (PIX_H > 1) ? $clog2(PIX_H) : 1;
  localparam int WE_W  = BRAM_DW / 8;
  localparam logic [15:0] HOLD_LAST =
    (TIMEOUT_CYC > 0) ? 16'(TIMEOUT_CYC - 1) : 16'd0;

  function automatic logic [WE_W-1:0] mk_mask(input int n);
    logic [WE_W-1:0] r;
    for (int j = 0; j < WE_W; j++)
      r[j] = (j < n);
    return r;
  endfunction

  localparam logic [WE_W-1:0] WE_MASK = mk_mask(PIX_H);

  function automatic logic [BRAM_DW-1:0] pack_row(
    input logic [PIX_H-1:0][7:0] row
  );
    logic [BRAM_DW-1:0] r;
    r = '0;
    for (int j = 0; j < PIX_H; j++)
      r[j*8 +: 8] = row[j];
    return r;
  endfunction

  if (PIX_H * 8 > BRAM_DW) begin : g_dw_chk
    $error("PIX_H*8 exceeds BRAM_DW");
  end
  if (CH_STRIDE < PIX_H) begin : g_stride_chk
    $error("CH_STRIDE smaller than PIX_H");
  end

  cap_st_e                         state, state_nxt;
  logic [CH_W-1:0]                 ch_idx, ld_ch;
  logic [COL_W-1:0]                col_idx;
  logic [15:0]                     hold_cnt;
  fmap_mode_e                      mode_q, mode_eff;
  logic [NUM_CH-1:0][PIX_H-1:0][7:0] gray_d, gray_q;
  logic [PIX_H-1:0][7:0]           ld_row;
  logic [ADDR_W-1:0]               ld_addr;
  logic                            hs, last_ch, last_col;
  logic                            ld_en, ld_last;
  logic                            done_q;
  logic [15:0]                     frame_q;
  logic [ADDR_W-1:0]               addr_q;
  logic [BRAM_DW-1:0]              data_q;
  logic [WE_W-1:0]                 we_q;

  assign hs       = valid_col && ready_col;
  assign last_ch  = (ch_idx == CH_W'(NUM_CH - 1));
  assign last_col = (col_idx == COL_W'(PIX_H - 1));
  assign mode_eff = (col_idx == '0) ? fmap_mode_e'(cfg_mode)
                                    : mode_q;

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    for (genvar p = 0; p < PIX_H; p++) begin : g_px
      fp16_to_gray8 u_cvt (
        .fp16 (data_col[c][p]),
        .mode (mode_eff),
        .gray (gray_d[c][p])
      );
    end
  end

  // outputs are preloaded one edge ahead of each write cycle
  assign ld_en   = hs || (state == WRITE && !last_ch);
  assign ld_ch   = hs ? '0 : ch_idx + 1'b1;
  assign ld_last = ld_en && (ld_ch == CH_W'(NUM_CH - 1))
                   && last_col;
  assign ld_row  = hs ? gray_d[0] : gray_q[ld_ch];
  assign ld_addr = ADDR_W'(BASE_ADDR + int'(ld_ch) * CH_STRIDE
                           + int'(col_idx));

  // state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // next-state logic
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:
        if (hs) state_nxt = WRITE;
      WRITE:
        if (last_ch)
          state_nxt = (last_col && TIMEOUT_CYC != 0)
                      ? HOLDOFF : IDLE;
      HOLDOFF:
        if (hold_cnt == HOLD_LAST) state_nxt = IDLE;
      default:
        state_nxt = IDLE;
    endcase
  end

  // handshake and status outputs
  always_comb begin
    ready_col = (state == IDLE);
    busy      = (state != IDLE);
  end

  assign bram_addr_a   = addr_q;
  assign bram_wrdata_a = data_q;
  assign bram_we_a     = we_q;
  assign write_done    = done_q;
  assign frame_cnt     = frame_q;

  // capture, indices, hold-off timer and write port registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gray_q   <= '0;
      mode_q   <= FM_CLAMP;
      ch_idx   <= '0;
      col_idx  <= '0;
      hold_cnt <= '0;
      addr_q   <= '0;
      data_q   <= '0;
      we_q     <= '0;
      done_q   <= 1'b0;
      frame_q  <= '0;
    end else begin
      if (hs) begin
        gray_q <= gray_d;
        if (col_idx == '0) mode_q <= mode_eff;
      end
      if (hs)
        ch_idx <= '0;
      else if (state == WRITE)
        ch_idx <= last_ch ? '0 : ch_idx + 1'b1;
      if (state == WRITE && last_ch)
        col_idx <= last_col ? '0 : col_idx + 1'b1;
      hold_cnt <= (state == HOLDOFF) ? hold_cnt + 16'd1 : '0;
      we_q     <= ld_en ? WE_MASK : '0;
      if (ld_en) begin
        addr_q <= ld_addr;
        data_q <= pack_row(ld_row);
      end
      done_q <= ld_last;
      if (ld_last) frame_q <= frame_q + 16'd1;
    end
  end

endmodule
